// File: rtl/axi4_lite_write_arbiter.sv
// axi4_lite_write_arbiter
//   Shares one AXI4-Lite write master between two requesters (port 0: LSU
//   store path, port 1: CSR/debug write path). Round-robin arbitration in
//   IDLE, latches the winner's address/data, drives the master's Start/Finish
//   level handshake and returns a one-cycle done pulse (plus err on watchdog
//   timeout) to the granted requester.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req0/addr0/data0  requester 0 request (level, held until done0), address, data
//   req1/addr1/data1  requester 1, same as port 0
//   done0/done1       one-cycle completion (or abort) pulse per requester
//   err               one-cycle pulse with done when the transfer timed out
//   busy              high whenever not IDLE
//   grant_id          current/last granted requester
//   m_start           Start to the write master
//   m_addr/m_data     WRITE_ADDR / WRITE_DATA to the master
//   m_finish          Finish from the master (high while master is in hold)
//
// TIMEOUT must be >= 2 and CNT_W wide enough to hold TIMEOUT.
module axi4_lite_write_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    output logic              done0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              done1,
    output logic              err,
    output logic              busy,
    output logic              grant_id,
    output logic              m_start,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_finish
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              last_grant, last_grant_nxt;
    logic              grant_id_nxt;
    logic              m_start_nxt;
    logic [ADDR_W-1:0] m_addr_nxt;
    logic [DATA_W-1:0] m_data_nxt;
    logic [1:0]        done_nxt;
    logic              err_nxt;
    logic              busy_nxt;
    logic              win;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        grant_id_nxt   = grant_id;
        m_start_nxt    = m_start;
        m_addr_nxt     = m_addr;
        m_data_nxt     = m_data;
        done_nxt       = 2'b00;
        err_nxt        = 1'b0;
        busy_nxt       = busy;
        // Tie goes to the port not served last; a lone requester always wins.
        win            = (req0 && req1) ? ~last_grant : req1;

        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    m_addr_nxt     = win ? addr1 : addr0;
                    m_data_nxt     = win ? data1 : data0;
                    grant_id_nxt   = win;
                    last_grant_nxt = win;
                    m_start_nxt    = 1'b1;
                    cnt_nxt        = '0;
                    busy_nxt       = 1'b1;
                    state_nxt      = GRANT;
                end
            end
            GRANT: begin
                cnt_nxt = cnt + 1'b1;
                // Finish wins over a timeout landing on the same cycle.
                if (m_finish) begin
                    m_start_nxt        = 1'b0;
                    done_nxt[grant_id] = 1'b1;
                    state_nxt          = RELEASE;
                end else if (cnt == CNT_LAST) begin
                    m_start_nxt        = 1'b0;
                    done_nxt[grant_id] = 1'b1;
                    err_nxt            = 1'b1;
                    state_nxt          = RELEASE;
                end
            end
            RELEASE: begin
                // Wait for the master to leave its hold state; no watchdog here.
                if (!m_finish) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                m_start_nxt = 1'b0;
                busy_nxt    = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;   // port 0 wins the first tie
            grant_id   <= 1'b0;
            m_start    <= 1'b0;
            m_addr     <= '0;
            m_data     <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_grant <= last_grant_nxt;
            grant_id   <= grant_id_nxt;
            m_start    <= m_start_nxt;
            m_addr     <= m_addr_nxt;
            m_data     <= m_data_nxt;
            done0      <= done_nxt[0];
            done1      <= done_nxt[1];
            err        <= err_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_axi4_lite_write_arbiter.sv
module tb_axi4_lite_write_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 8;

    logic          clk;
    logic          rst;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic          done0, done1, err, busy, grant_id, m_start, m_finish;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    int checks = 0;
    int errors = 0;
    int n_d0   = 0;
    int n_d1   = 0;

    axi4_lite_write_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .data0(data0), .done0(done0),
        .req1(req1), .addr1(addr1), .data1(data1), .done1(done1),
        .err(err), .busy(busy), .grant_id(grant_id),
        .m_start(m_start), .m_addr(m_addr), .m_data(m_data),
        .m_finish(m_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses away from the active edge.
    always @(negedge clk) begin
        if (done0 === 1'b1) n_d0++;
        if (done1 === 1'b1) n_d1++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    // Run one transfer whose request is already set up.
    // fin_after: cycles after the first m_start sample before finish rises (-1 = never).
    // hold: extra cycles finish stays high after done.
    task automatic xfer(input string tag, input bit port, input int fin_after,
                        input int hold, input bit exp_err,
                        input logic [63:0] ea, input logic [63:0] ed, input bit wiggle);
        int w;
        int hi;
        w = 0;
        do begin
            step();
            w++;
        end while (!m_start && w < 10);
        chk({tag, " start_latency"}, 64'(w), 64'd1);
        chk({tag, " m_addr"}, m_addr, ea);
        chk({tag, " m_data"}, m_data, ed);
        chk({tag, " grant_id"}, 64'(grant_id), 64'(port));
        chk({tag, " busy"}, 64'(busy), 64'd1);
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            if (fin_after >= 0 && hi - 1 == fin_after) m_finish = 1'b1;
            if (wiggle && hi == 2) begin
                addr0 = ~addr0;
                data0 = ~data0;
                addr1 = ~addr1;
            end
            step();
            if (done0 || done1) break;
            hi++;
        end
        chk({tag, " start_cycles"}, 64'(hi), (fin_after < 0) ? 64'(TO) : 64'(fin_after + 1));
        chk({tag, " done_port"}, 64'({done1, done0}), port ? 64'd2 : 64'd1);
        chk({tag, " err"}, 64'(err), 64'(exp_err));
        chk({tag, " m_start_low"}, 64'(m_start), 64'd0);
        chk({tag, " addr_stable"}, m_addr, ea);
        if (port) req1 = 1'b0; else req0 = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, " release_hold"}, 64'({busy, done1, done0, err}), 64'b1000);
        end
        m_finish = 1'b0;
        step();
        chk({tag, " idle"}, 64'({busy, m_start, done1, done0, err}), 64'd0);
    endtask

    initial begin
        int d1_before;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; m_finish = 1'b0;
        addr0 = '0; data0 = '0; addr1 = '0; data1 = '0;

        // Reset state
        reset_dut();
        chk("rst outs", 64'({m_start, done0, done1, err, busy, grant_id}), 64'd0);
        chk("rst m_addr", m_addr, 64'd0);
        chk("rst m_data", m_data, 64'd0);

        // Single port 0, finish 4 cycles after m_start, held one extra cycle
        req0 = 1'b1; addr0 = 64'h8000_0010; data0 = 64'hDEAD_BEEF_0000_0001;
        xfer("single0", 1'b0, 4, 1, 1'b0, 64'h8000_0010, 64'hDEAD_BEEF_0000_0001, 1'b0);
        chk("single0 done0_count", 64'(n_d0), 64'd1);
        chk("single0 done1_count", 64'(n_d1), 64'd0);

        // Tie and round-robin from reset: 0,1,0,1
        reset_dut();
        addr0 = 64'h100; data0 = 64'hA0; addr1 = 64'h200; data1 = 64'hB1;
        req0 = 1'b1; req1 = 1'b1;
        xfer("rr1", 1'b0, 2, 0, 1'b0, 64'h100, 64'hA0, 1'b0);
        req0 = 1'b1;
        xfer("rr2", 1'b1, 2, 0, 1'b0, 64'h200, 64'hB1, 1'b0);
        req1 = 1'b1;
        xfer("rr3", 1'b0, 1, 0, 1'b0, 64'h100, 64'hA0, 1'b0);
        req0 = 1'b1;
        xfer("rr4", 1'b1, 0, 0, 1'b0, 64'h200, 64'hB1, 1'b0);
        req0 = 1'b0;
        chk("rr done counts", 64'({n_d0[15:0], n_d1[15:0]}), {32'd0, 16'd3, 16'd2});

        // Lone requester 1, three back-to-back transfers (last_grant is already 1)
        addr1 = 64'h300; data1 = 64'hC3;
        req1 = 1'b1;
        xfer("lone1a", 1'b1, 3, 0, 1'b0, 64'h300, 64'hC3, 1'b0);
        req1 = 1'b1;
        xfer("lone1b", 1'b1, 3, 0, 1'b0, 64'h300, 64'hC3, 1'b0);
        req1 = 1'b1;
        xfer("lone1c", 1'b1, 3, 0, 1'b0, 64'h300, 64'hC3, 1'b0);

        // Timeout: master never finishes; addr0/data0 wiggled mid-GRANT
        addr0 = 64'h4444; data0 = 64'h5555;
        req0 = 1'b1;
        xfer("timeout", 1'b0, -1, 0, 1'b1, 64'h4444, 64'h5555, 1'b1);
        chk("timeout m_data_stable", m_data, 64'h5555);

        // Finish on the same cycle the watchdog expires: no err
        addr0 = 64'h6666; data0 = 64'h7777;
        req0 = 1'b1;
        xfer("fin_vs_to", 1'b0, TO - 1, 0, 1'b0, 64'h6666, 64'h7777, 1'b0);

        // Reset during GRANT on port 1: abort, no done pulse
        addr1 = 64'h9999; data1 = 64'h8888;
        req1 = 1'b1;
        step();
        chk("midrst start", 64'({m_start, grant_id}), 64'b11);
        step();
        d1_before = n_d1;
        rst = 1'b1; req1 = 1'b0;
        step();
        rst = 1'b0;
        chk("midrst outs", 64'({m_start, done0, done1, err, busy, grant_id}), 64'd0);
        chk("midrst m_addr", m_addr, 64'd0);
        chk("midrst m_data", m_data, 64'd0);
        repeat (3) step();
        chk("midrst no_done", 64'(n_d1 - d1_before), 64'd0);
        chk("midrst idle", 64'({busy, m_start}), 64'd0);

        // After reset, a tie goes to port 0 again
        addr0 = 64'hAAAA; data0 = 64'hBBBB; addr1 = 64'hCCCC; data1 = 64'hDDDD;
        req0 = 1'b1; req1 = 1'b1;
        xfer("post_rst_tie", 1'b0, 1, 0, 1'b0, 64'hAAAA, 64'hBBBB, 1'b0);
        req1 = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_write_arbiter.md
Name: axi4_lite_write_arbiter

Overview:
- Shares one AXI4-Lite write master between two requesters: port 0 is the LSU store path and port 1 is the CSR/debug write path.
- Arbitrates round-robin and latches the winner's address and data.
- Sequences the master's Start/Finish level handshake: Start is held until Finish, then released until Finish drops.
- Returns a one-cycle done pulse, plus a timeout error flag from a watchdog counter, to the granted requester.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- TIMEOUT, 1024, max cycles in GRANT waiting for m_finish before aborting; must be >= 2.
- CNT_W, 11, watchdog counter width; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 write request; level, held until done0.
- addr0  in  ADDR_W  requester 0 write address.
- data0  in  DATA_W  requester 0 write data.
- done0  out  1  one-cycle pulse: requester 0 write completed or aborted.
- req1, addr1, data1, done1: same as port 0, for requester 1.
- err  out  1  one-cycle pulse coincident with done0/done1 when the transfer timed out.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  index of the current/last granted requester.
- m_start  out  1  Start to the write master.
- m_addr  out  ADDR_W  WRITE_ADDR to the master.
- m_data  out  DATA_W  WRITE_DATA to the master.
- m_finish  in  1  Finish from the master; high while the master is in its hold state.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State goes to IDLE.
  - m_start, done0, done1, err, busy = 0.
  - m_addr, m_data = 0; grant_id = 0.
  - last_grant = 1, so port 0 wins the first tie.
  - Watchdog counter = 0.
  - Reset mid-transfer aborts without a done pulse.
- All outputs are registered.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant !last_grant.
  - On grant: latch addr/data into m_addr/m_data, set grant_id and last_grant, set m_start=1, clear the counter, go to GRANT.
  - Cycle 0 = req seen; m_start is high at cycle 1.
- GRANT:
  - m_start stays 1; m_addr and m_data are stable.
  - Counter increments each cycle.
  - If m_finish=1: next cycle m_start=0, pulse done[grant_id]=1, go to RELEASE.
  - Else if counter == TIMEOUT-1: m_start=0, pulse done[grant_id]=1 and err=1, go to RELEASE.
  - m_finish has priority over timeout when both occur in the same cycle (err=0).
- RELEASE:
  - m_start=0; done/err are low after the single pulse cycle.
  - When m_finish=0, go to IDLE; busy drops the same edge.
  - Stays in RELEASE while m_finish=1; no watchdog in this state.
- Arbitration happens only in IDLE. Changes to req/addr/data of either port during GRANT/RELEASE are ignored.
- Requesters must deassert req in the cycle after done; a req still high in IDLE is treated as a new request.
- Round-robin: after port X is served, port !X wins the next simultaneous request. A lone requester is always served regardless of last_grant.
- Minimum turnaround, req to done, with a zero-wait master: m_start at cycle 1; the master reaches hold and raises finish a few cycles later; done is registered one cycle after finish is seen.
- Back-to-back transfers: at least one IDLE cycle separates consecutive grants.
- No write strobes or response codes are handled; the master always writes all byte lanes.

Test Plan:
- Single port 0:
  - Stimulus: req0=1, addr0=0x8000_0010, data0=0xDEAD_BEEF_0000_0001; model master raises finish 4 cycles after m_start.
  - Required: m_start=1 at cycle 1 with m_addr/m_data matching; done0 pulses exactly once, one cycle after finish; err=0; done1 never asserts; busy low after finish drops.
- Tie and round-robin:
  - Stimulus: req0=req1=1 from reset, each requester re-requesting immediately after its done.
  - Required: grant order 0,1,0,1 over 4 transfers; grant_id matches each done pulse.
- Lone requester repeat:
  - Stimulus: only req1, 3 consecutive transfers.
  - Required: all 3 served to port 1, each separated by at least 1 IDLE cycle.
- Timeout:
  - Stimulus: TIMEOUT=8; master never raises finish.
  - Required: m_start high for exactly 8 cycles, then done0 and err pulse together; return to IDLE next cycle.
- Finish vs timeout on the same cycle:
  - Stimulus: finish asserted on counter==TIMEOUT-1.
  - Required: done pulse with err=0.
- Reset mid-GRANT, plus input stability:
  - Stimulus: rst=1 for 1 cycle while m_start=1; separately, change addr0 during GRANT.
  - Required: after reset, all outputs 0 and no done pulse; with the addr0 change, m_addr stays at the latched value.
